regfile_scoreboard: RTL and testbench

Parametrised next-generation CPU register file with two asynchronous read ports, one synchronous write port, optional hardwired-zero register, and optional write-to-read bypass. It adds a per-register busy scoreboard. Issue logic marks a destination register busy, and the writeback port clears it. The decode/hazard stage uses this for RAW stall detection on multicycle ops such as loads.

---
 rtl/regfile_scoreboard.sv | 129 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// ------------------
// CPU register file with two combinational read ports, one synchronous write
// (writeback) port and a per-register busy scoreboard used for RAW hazard
// detection on multicycle ops. Issue marks a destination busy, writeback
// clears it, flush clears everything.
//
// Parameters:
//   DATA_W   register width
//   NUM_REGS number of architectural registers (2..256, any value)
//   ZERO_REG 1 = register 0 reads 0, ignores writes, is never busy
//   BYPASS   1 = same-cycle write data is forwarded to the read ports
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   rs1_addr/rs2_addr        read addresses
//   rd1_data/rd2_data        read data (combinational)
//   rs1_busy/rs2_busy        read register has a pending write
//   wr_en/wr_addr/wr_data    writeback port
//   issue_en/issue_addr      mark a destination register busy
//   flush                    clear all busy bits
//   busy_vec                 registered scoreboard, bit i = register i busy
module regfile_scoreboard #(
  parameter int DATA_W   = 19,
  parameter int NUM_REGS = 16,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [DATA_W-1:0]   rd1_data,
  output logic [DATA_W-1:0]   rd2_data,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0]   mem_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic                wr_ok;
  logic                issue_ok;

  // An address names a real, modifiable register: in range and not the
  // hardwired zero register. Everything aimed elsewhere is silently dropped.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = (32'(a) < 32'(NUM_REGS));
    if (ZERO_REG != 0 && a == '0) ok = 1'b0;
    return ok;
  endfunction

  assign wr_ok    = wr_en && addr_ok(wr_addr);
  assign issue_ok = issue_en && addr_ok(issue_addr);

  // Scoreboard next state. Flush dominates; issue beats a same-cycle
  // writeback to the same register because the new op owns the result.
  always_comb begin
    busy_next = busy_reg;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (flush)
        busy_next[i] = 1'b0;
      else if (issue_ok && issue_addr == ADDR_W'(i))
        busy_next[i] = 1'b1;
      else if (wr_ok && wr_addr == ADDR_W'(i))
        busy_next[i] = 1'b0;
    end
  end

  // Register array and scoreboard. The zero register and out-of-range
  // addresses never match wr_ok, so register 0 stays at its reset value
  // when ZERO_REG is set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg <= '0;
      for (int i = 0; i < NUM_REGS; i++) mem_reg[i] <= '0;
    end else begin
      busy_reg <= busy_next;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && wr_addr == ADDR_W'(i)) mem_reg[i] <= wr_data;
      end
    end
  end

  assign busy_vec = busy_reg;

  // Read ports. A forwarded write also forces busy low: the consumer gets
  // the value it was waiting for in this very cycle.
  always_comb begin
    rd1_data = '0;
    rs1_busy = 1'b0;
    rd2_data = '0;
    rs2_busy = 1'b0;
    if (addr_ok(rs1_addr)) begin
      if (BYPASS != 0 && wr_ok && wr_addr == rs1_addr) begin
        rd1_data = wr_data;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rs1_addr == ADDR_W'(i)) begin
            rd1_data = mem_reg[i];
            rs1_busy = busy_reg[i];
          end
        end
      end
    end
    if (addr_ok(rs2_addr)) begin
      if (BYPASS != 0 && wr_ok && wr_addr == rs2_addr) begin
        rd2_data = wr_data;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rs2_addr == ADDR_W'(i)) begin
            rd2_data = mem_reg[i];
            rs2_busy = busy_reg[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
// ---------------------
// Directed bench for regfile_scoreboard. Three instances: u_a (defaults),
// u_b (BYPASS=0, same stimulus as u_a) and u_c (NUM_REGS=12, DATA_W=32,
// ZERO_REG=0). Stimulus pushes hand-computed expectations into a queue;
// a monitor drains the queue on each falling edge and compares.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Shared stimulus for u_a / u_b
  logic [3:0]  a_rs1, a_rs2, a_wr_addr, a_issue_addr;
  logic [18:0] a_wr_data;
  logic        a_wr_en, a_issue_en, a_flush;
  logic [18:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;
  logic [15:0] a_busy, b_busy;

  // Stimulus for u_c
  logic [3:0]  c_rs1, c_rs2, c_wr_addr, c_issue_addr;
  logic [31:0] c_wr_data;
  logic        c_wr_en, c_issue_en, c_flush;
  logic [31:0] c_rd1, c_rd2;
  logic        c_rs1_busy, c_rs2_busy;
  logic [11:0] c_busy;

  regfile_scoreboard u_a (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(a_rs1), .rs2_addr(a_rs2),
    .rd1_data(a_rd1), .rd2_data(a_rd2),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .issue_en(a_issue_en), .issue_addr(a_issue_addr),
    .flush(a_flush), .busy_vec(a_busy)
  );

  regfile_scoreboard #(.BYPASS(0)) u_b (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(a_rs1), .rs2_addr(a_rs2),
    .rd1_data(b_rd1), .rd2_data(b_rd2),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .issue_en(a_issue_en), .issue_addr(a_issue_addr),
    .flush(a_flush), .busy_vec(b_busy)
  );

  regfile_scoreboard #(.DATA_W(32), .NUM_REGS(12), .ZERO_REG(0)) u_c (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(c_rs1), .rs2_addr(c_rs2),
    .rd1_data(c_rd1), .rd2_data(c_rd2),
    .rs1_busy(c_rs1_busy), .rs2_busy(c_rs2_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .issue_en(c_issue_en), .issue_addr(c_issue_addr),
    .flush(c_flush), .busy_vec(c_busy)
  );

  // Observed-signal selectors
  localparam int A_RD1 = 0, A_RD2 = 1, A_RS1B = 2, A_RS2B = 3, A_BUSY = 4;
  localparam int B_RD1 = 5, B_RS1B = 6, B_BUSY = 7;
  localparam int C_RD1 = 8, C_RS1B = 9, C_BUSY = 10;

  typedef struct {
    int          sel;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      A_RD1:   return 32'(a_rd1);
      A_RD2:   return 32'(a_rd2);
      A_RS1B:  return 32'(a_rs1_busy);
      A_RS2B:  return 32'(a_rs2_busy);
      A_BUSY:  return 32'(a_busy);
      B_RD1:   return 32'(b_rd1);
      B_RS1B:  return 32'(b_rs1_busy);
      B_BUSY:  return 32'(b_busy);
      C_RD1:   return c_rd1;
      C_RS1B:  return 32'(c_rs1_busy);
      C_BUSY:  return 32'(c_busy);
      default: return 32'hDEAD_0000;
    endcase
  endfunction

  task automatic expect_val(input int sel, input string name, input logic [31:0] v);
    exp_t e;
    e.sel  = sel;
    e.name = name;
    e.exp  = v;
    q.push_back(e);
  endtask

  // Monitor: checks every queued expectation against the outputs seen
  // mid-cycle, away from the active edge.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = actual(e.sel);
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h, expected %h (t=%0t)", e.name, act, e.exp, $time);
        end else begin
          $display("ok   %s: %h (t=%0t)", e.name, act, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wr_en = 1'b0; a_issue_en = 1'b0; a_flush = 1'b0;
    c_wr_en = 1'b0; c_issue_en = 1'b0; c_flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    a_rs1 = 4'd3; a_rs2 = 4'd0; a_wr_addr = 4'd3; a_issue_addr = 4'd0;
    a_wr_data = 19'h12345; a_wr_en = 1'b1; a_issue_en = 1'b0; a_flush = 1'b0;
    c_rs1 = 4'd0; c_rs2 = 4'd0; c_wr_addr = 4'd0; c_issue_addr = 4'd0;
    c_wr_data = 32'h0; c_wr_en = 1'b0; c_issue_en = 1'b0; c_flush = 1'b0;

    // Writes during reset are discarded
    tick(); tick();
    a_wr_en = 1'b0;
    expect_val(A_RD1, "reset_rd1_r3", 32'h0);
    expect_val(A_BUSY, "reset_busy_vec", 32'h0);
    expect_val(B_RD1, "reset_b_rd1_r3", 32'h0);
    expect_val(C_BUSY, "reset_c_busy_vec", 32'h0);

    // Release reset, write r3
    tick();
    reset_n = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 19'h12345; a_rs1 = 4'd3;
    expect_val(A_RD1, "bypass_r3", 32'h12345);
    expect_val(B_RD1, "nobypass_r3_before", 32'h0);
    tick();
    idle();
    expect_val(A_RD1, "r3_after_write", 32'h12345);
    expect_val(B_RD1, "b_r3_after_write", 32'h12345);

    // Zero register ignores writes and is not forwarded
    tick();
    a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 19'h7FFFF; a_rs2 = 4'd0;
    expect_val(A_RD2, "r0_during_write", 32'h0);
    tick();
    idle();
    expect_val(A_RD2, "r0_after_write", 32'h0);

    // Bypass on both ports
    tick();
    a_rs1 = 4'd5; a_rs2 = 4'd5;
    a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 19'h00ABC;
    expect_val(A_RD1, "bypass_rd1_r5", 32'h00ABC);
    expect_val(A_RD2, "bypass_rd2_r5", 32'h00ABC);
    expect_val(B_RD1, "nobypass_r5_before", 32'h0);
    tick();
    idle();
    expect_val(B_RD1, "nobypass_r5_after", 32'h00ABC);
    expect_val(A_RD2, "r5_after", 32'h00ABC);

    // Scoreboard: issue r7, wait, writeback
    tick();
    a_issue_en = 1'b1; a_issue_addr = 4'd7; a_rs1 = 4'd7;
    expect_val(A_RS1B, "r7_busy_before_edge", 32'h0);
    tick();
    idle();
    expect_val(A_BUSY, "busy_vec_r7", 32'h0080);
    expect_val(A_RS1B, "rs1_busy_r7", 32'h1);
    tick(); tick(); tick();
    expect_val(A_RS1B, "rs1_busy_r7_held", 32'h1);
    tick();
    a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 19'h00042;
    expect_val(A_RS1B, "r7_busy_bypassed", 32'h0);
    expect_val(B_RS1B, "b_r7_busy_until_edge", 32'h1);
    expect_val(A_RD1, "r7_bypass_data", 32'h00042);
    tick();
    idle();
    expect_val(A_BUSY, "busy_vec_r7_cleared", 32'h0);
    expect_val(B_BUSY, "b_busy_vec_r7_cleared", 32'h0);
    expect_val(A_RD1, "r7_data", 32'h00042);

    // Issue / writeback collision on r9
    tick();
    a_issue_en = 1'b1; a_issue_addr = 4'd9;
    tick();
    a_wr_en = 1'b1; a_wr_addr = 4'd9; a_wr_data = 19'h00011; a_rs1 = 4'd9;
    expect_val(A_RS1B, "r9_busy_bypassed", 32'h0);
    tick();
    idle();
    expect_val(A_BUSY, "collision_busy_r9", 32'h0200);
    expect_val(A_RD1, "collision_data_r9", 32'h00011);
    expect_val(A_RS1B, "collision_rs1_busy", 32'h1);
    expect_val(B_RD1, "b_collision_data_r9", 32'h00011);

    // Flush: set 2, 4, 6 (9 still busy)
    tick(); a_issue_en = 1'b1; a_issue_addr = 4'd2;
    tick(); a_issue_addr = 4'd4;
    tick(); a_issue_addr = 4'd6;
    tick();
    idle();
    a_rs2 = 4'd4;
    expect_val(A_BUSY, "pre_flush_busy_vec", 32'h0254);
    expect_val(A_RS2B, "rs2_busy_r4", 32'h1);
    tick();
    a_flush = 1'b1; a_issue_en = 1'b1; a_issue_addr = 4'd8;
    a_wr_en = 1'b1; a_wr_addr = 4'd2; a_wr_data = 19'h00555;
    tick();
    idle();
    a_rs1 = 4'd2;
    expect_val(A_BUSY, "post_flush_busy_vec", 32'h0);
    expect_val(A_RD1, "flush_concurrent_write", 32'h00555);
    expect_val(A_RS1B, "post_flush_rs1_busy", 32'h0);

    // Parametric instance: r0 writable and can be busy
    tick();
    c_wr_en = 1'b1; c_wr_addr = 4'd0; c_wr_data = 32'hDEADBEEF;
    c_issue_en = 1'b1; c_issue_addr = 4'd0; c_rs1 = 4'd0;
    tick();
    idle();
    expect_val(C_RD1, "c_r0_data", 32'hDEADBEEF);
    expect_val(C_BUSY, "c_r0_busy_vec", 32'h001);
    expect_val(C_RS1B, "c_r0_rs1_busy", 32'h1);
    tick();
    c_wr_en = 1'b1; c_wr_addr = 4'd13; c_wr_data = 32'h12345678;
    c_issue_en = 1'b1; c_issue_addr = 4'd13; c_rs1 = 4'd13;
    expect_val(C_RD1, "c_r13_no_bypass", 32'h0);
    expect_val(C_RS1B, "c_r13_busy", 32'h0);
    tick();
    idle();
    c_wr_en = 1'b1; c_wr_addr = 4'd11; c_wr_data = 32'hA5A5A5A5;
    expect_val(C_BUSY, "c_oob_no_change", 32'h001);
    expect_val(C_RD1, "c_r13_read", 32'h0);
    tick();
    idle();
    c_rs1 = 4'd11;
    c_wr_en = 1'b1; c_wr_addr = 4'd0; c_wr_data = 32'h1;
    expect_val(C_RD1, "c_r11_top_reg", 32'hA5A5A5A5);
    tick();
    idle();
    c_rs1 = 4'd0;
    expect_val(C_BUSY, "c_r0_cleared", 32'h0);
    expect_val(C_RD1, "c_r0_rewritten", 32'h1);

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
